// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch sequencer that sits directly in front of pre-decode.
//   It reads instruction memory at the program counter and holds each
//   returned word in a one-entry register (instr_q). Pre-decode looks at
//   instr_q combinationally and returns branch/end/flush flags. Those flags
//   decide whether fetch stalls for a branch, drains the readback buffer,
//   or terminates. Words go downstream over a valid/ready handshake.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start, start_pc     start/restart pulse and first fetch address
//   imem_en/addr/rdata  instruction-memory read port (rdata one cycle after en)
//   instr_q             held instruction word
//   pd_*                pre-decode flags describing instr_q
//   out_valid/ready     downstream handshake
//   br_resolve_valid,
//   br_taken, br_target branch resolution from exec (also the sleep wake-up)
//   flush_req/done      readback-buffer drain request/acknowledge
//   busy, done          status
module fetch_stage #(
  parameter int INSTR_W = 64,
  parameter int ADDR_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_pc,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_q,
  input  logic               pd_is_branch,
  input  logic               pd_is_end,
  input  logic               pd_need_flush,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               br_resolve_valid,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               flush_req,
  input  logic               flush_done,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_BR,
    S_WAIT_FLUSH,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                inflight_q, inflight_d;
  logic                instr_valid_q, instr_valid_d;
  logic                flush_ok_q, flush_ok_d;
  logic                done_q, done_d;
  logic [INSTR_W-1:0]  instr_d;

  logic hs;
  logic hs_normal;

  // A word needing a flush is only offered once the drain has been
  // acknowledged; after that it is offered regardless of buffer space so an
  // oversized read cannot deadlock.
  assign out_valid = instr_valid_q && (state_q == S_FETCH) &&
                     (!pd_need_flush || flush_ok_q);
  assign hs        = out_valid && out_ready;
  assign hs_normal = hs && !pd_is_branch && !pd_is_end;

  // A new read may only go out when the holding register is empty or is
  // being handed off in this very cycle; branches and end words never allow
  // a fetch behind them.
  assign imem_en   = (state_q == S_FETCH) && !inflight_q &&
                     (!instr_valid_q || hs_normal);
  assign imem_addr = pc_q;
  assign flush_req = (state_q == S_WAIT_FLUSH);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = done_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    instr_valid_d = instr_valid_q;
    flush_ok_d    = flush_ok_q;
    done_d        = done_q;
    instr_d       = instr_q;

    if (hs) begin
      instr_valid_d = 1'b0;
      flush_ok_d    = 1'b0;
    end

    // Capture overrides the handshake clear: with a single read in flight
    // the returning word is always the next one to hold.
    if (inflight_q) begin
      instr_d       = imem_rdata;
      instr_valid_d = 1'b1;
      inflight_d    = 1'b0;
    end

    if (imem_en) begin
      pc_d       = pc_q + ADDR_W'(1);
      inflight_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pc_d       = start_pc;
          done_d     = 1'b0;
          flush_ok_d = 1'b0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (instr_valid_q) begin
          if (pd_need_flush && !flush_ok_q) begin
            state_d = S_WAIT_FLUSH;
          end else if (pd_is_end && hs) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (pd_is_branch && hs) begin
            state_d = S_WAIT_BR;
          end
        end
      end
      S_WAIT_FLUSH: begin
        if (flush_done) begin
          flush_ok_d = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_WAIT_BR: begin
        // Sleep words arrive here too and are woken with br_taken=0.
        if (br_resolve_valid) begin
          if (br_taken) begin
            pc_d = br_target;
          end
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      flush_ok_q    <= 1'b0;
      done_q        <= 1'b0;
      instr_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      instr_valid_q <= instr_valid_d;
      flush_ok_q    <= flush_ok_d;
      done_q        <= done_d;
      instr_q       <= instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed timing scenarios followed by randomized
// programs checked against a transaction-level program-flow model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  start_pc;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [63:0] imem_rdata;
  logic [63:0] instr_q;
  logic        pd_is_branch;
  logic        pd_is_end;
  logic        pd_need_flush;
  logic        out_valid;
  logic        out_ready;
  logic        br_resolve_valid;
  logic        br_taken;
  logic [9:0]  br_target;
  logic        flush_req;
  logic        flush_done;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_err    = 0;

  logic [63:0] mem [1024];

  fetch_stage #(.INSTR_W(64), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_q(instr_q), .pd_is_branch(pd_is_branch), .pd_is_end(pd_is_end),
    .pd_need_flush(pd_need_flush), .out_valid(out_valid), .out_ready(out_ready),
    .br_resolve_valid(br_resolve_valid), .br_taken(br_taken), .br_target(br_target),
    .flush_req(flush_req), .flush_done(flush_done), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: registered read, data valid one cycle after enable.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  // Pre-decode model: all-zero word is end, bit 63 branch, bit 62 flush.
  assign pd_is_end     = (instr_q == 64'd0);
  assign pd_is_branch  = instr_q[63];
  assign pd_need_flush = instr_q[62];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 normal, 1 branch, 2 flush, 3 end, 4 branch+flush
  function automatic logic [63:0] mk(input int kind);
    logic [63:0] w;
    w = {$urandom, $urandom};
    w[0]  = 1'b1;
    w[63] = (kind == 1 || kind == 4);
    w[62] = (kind == 2 || kind == 4);
    if (kind == 3) w = 64'd0;
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; flush_done = 1'b0;
    br_resolve_valid = 1'b0; br_taken = 1'b0; br_target = '0; start_pc = '0;
    step(); step();
    rst = 1'b0;
  endtask

  // Random program run; the model follows the architectural program flow:
  // sequential addresses, branch redirects on resolution, end terminates.
  task automatic rand_run(input int rdy_pct);
    logic [9:0]  m_pc, a, br_addr;
    logic [63:0] w, prev_instr;
    bit wait_br, end_seen, fl_active, flushed, finished;
    bit prev_en, prev_valid, prev_hs, hs;
    int br_cnt, fl_cnt, end_cnt;
    logic [9:0] q[$];
    wait_br = 0; end_seen = 0; fl_active = 0; flushed = 0; finished = 0;
    prev_en = 0; prev_valid = 0; prev_hs = 0; br_cnt = 0; fl_cnt = 0; end_cnt = 0;
    br_addr = '0; prev_instr = '0;
    q.delete();
    do_reset();
    start = 1'b1;
    start_pc = 10'($urandom_range(0, 1023));
    m_pc = start_pc;
    for (int c = 0; c < 3000 && !finished; c++) begin
      step();
      start = 1'b0; flush_done = 1'b0; br_resolve_valid = 1'b0; br_taken = 1'b0;
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      #1;
      hs = out_valid && out_ready;
      if (prev_valid && !prev_hs) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_instr", instr_q, prev_instr);
      end
      if (end_seen) begin
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_valid", out_valid, 0);
        end_cnt++;
        if (end_cnt == 3) finished = 1;
      end
      if (imem_en) begin
        chk("fetch_gap", prev_en, 0);
        chk("fetch_allowed", wait_br || end_seen, 0);
        chk("fetch_addr", imem_addr, m_pc);
        q.push_back(m_pc);
        m_pc = m_pc + 10'd1;
      end
      if (flush_req) begin
        chk("flush_blocks_valid", out_valid, 0);
        if (!fl_active) begin
          fl_active = 1;
          fl_cnt = $urandom_range(0, 6);
        end else if (fl_cnt == 0) begin
          flush_done = 1'b1;
          flushed = 1;
          fl_active = 0;
        end else begin
          fl_cnt--;
        end
      end
      if (hs) begin
        chk("hs_has_fetch", (q.size() != 0), 1);
        if (q.size() != 0) begin
          a = q.pop_front();
          w = mem[a];
          chk("hs_word", instr_q, w);
          if (w[62]) chk("hs_after_flush", flushed, 1);
          flushed = 0;
          if (w == 64'd0) begin
            end_seen = 1;
          end else if (w[63]) begin
            wait_br = 1;
            br_cnt = $urandom_range(0, 5);
            br_addr = a;
          end
        end
      end else if (wait_br) begin
        if (br_cnt == 0) begin
          br_resolve_valid = 1'b1;
          br_taken = 1'($urandom_range(0, 1));
          br_target = 10'($urandom_range(0, 1023));
          m_pc = br_taken ? br_target : br_addr + 10'd1;
          wait_br = 0;
        end else begin
          br_cnt--;
        end
      end
      prev_en = imem_en; prev_valid = out_valid; prev_hs = hs; prev_instr = instr_q;
    end
    chk("run_reaches_end", finished, 1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = mk(0);

    // Reset state
    do_reset();
    #1;
    chk("rst_en", imem_en, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_flush_req", flush_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_instr", instr_q, 0);

    // Straight line from 5, end word at 9, then restart at 0 and reset
    mem[9] = mk(3);
    do_reset();
    out_ready = 1'b1; start = 1'b1; start_pc = 10'd5;
    #1;
    chk("sl_idle_busy", busy, 0);
    step(); start = 1'b0; #1;
    chk("sl_c1_en", imem_en, 1);
    chk("sl_c1_addr", imem_addr, 5);
    step(); #1;
    chk("sl_c2_en", imem_en, 0);
    chk("sl_c2_valid", out_valid, 0);
    chk("sl_c2_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      step(); #1;
      chk("sl_hs_valid", out_valid, 1);
      chk("sl_hs_word", instr_q, mem[5 + k]);
      chk("sl_hs_en", imem_en, 1);
      chk("sl_hs_addr", imem_addr, 6 + k);
      step(); #1;
      chk("sl_gap_en", imem_en, 0);
      chk("sl_gap_valid", out_valid, 0);
    end
    step(); #1;
    chk("end_valid", out_valid, 1);
    chk("end_word", instr_q, 0);
    chk("end_no_fetch", imem_en, 0);
    step(); #1;
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_after_en", imem_en, 0);
    chk("end_after_valid", out_valid, 0);
    start = 1'b1; start_pc = 10'd0;
    step(); start = 1'b0; #1;
    chk("restart_done", done, 0);
    chk("restart_en", imem_en, 1);
    chk("restart_addr", imem_addr, 0);
    step(); rst = 1'b1; #1;
    step(); #1;
    chk("midrst_en", imem_en, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_flush_req", flush_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_instr", instr_q, 0);
    rst = 1'b0;
    step(); #1;
    chk("midrst_stale_instr", instr_q, 0);
    chk("midrst_stale_valid", out_valid, 0);

    // Backpressure on the first word
    mem[22] = mk(3);
    do_reset();
    out_ready = 1'b0; start = 1'b1; start_pc = 10'd20;
    step(); start = 1'b0; #1;
    chk("bp_c1_addr", imem_addr, 20);
    step(); step(); #1;
    chk("bp_valid", out_valid, 1);
    chk("bp_word", instr_q, mem[20]);
    chk("bp_no_fetch", imem_en, 0);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_word", instr_q, mem[20]);
      chk("bp_hold_no_fetch", imem_en, 0);
    end
    step(); out_ready = 1'b1; #1;
    chk("bp_resume_en", imem_en, 1);
    chk("bp_resume_addr", imem_addr, 21);
    step(); #1;
    chk("bp_gap_en", imem_en, 0);
    step(); #1;
    chk("bp_next_word", instr_q, mem[21]);
    chk("bp_next_addr", imem_addr, 22);

    // Branch taken at 3 to 0x3F0, then not-taken branch at 0x3F0
    mem[3] = mk(1); mem[10'h3F0] = mk(1);
    do_reset();
    out_ready = 1'b1; start = 1'b1; start_pc = 10'd2;
    step(); start = 1'b0; #1;
    chk("br_c1_addr", imem_addr, 2);
    step(); step(); #1;
    chk("br_c3_addr", imem_addr, 3);
    step(); step(); #1;
    chk("br_hs_word", instr_q, mem[3]);
    chk("br_hs_valid", out_valid, 1);
    chk("br_hs_no_fetch", imem_en, 0);
    br_resolve_valid = 1'b1; br_taken = 1'b1; br_target = 10'h155;
    step(); br_resolve_valid = 1'b0; #1;
    chk("br_wait_en", imem_en, 0);
    chk("br_wait_valid", out_valid, 0);
    chk("br_wait_busy", busy, 1);
    step(); #1;
    chk("br_early_resolve_ignored", imem_en, 0);
    br_resolve_valid = 1'b1; br_taken = 1'b1; br_target = 10'h3F0;
    step(); br_resolve_valid = 1'b0; #1;
    chk("br_taken_en", imem_en, 1);
    chk("br_taken_addr", imem_addr, 10'h3F0);
    step(); step(); #1;
    chk("br2_hs_word", instr_q, mem[10'h3F0]);
    step(); br_resolve_valid = 1'b1; br_taken = 1'b0; br_target = 10'h155; #1;
    step(); br_resolve_valid = 1'b0; #1;
    chk("br_not_taken_addr", imem_addr, 10'h3F1);
    chk("br_not_taken_en", imem_en, 1);

    // Flush handshake
    mem[30] = mk(2); mem[31] = mk(2); mem[32] = mk(3);
    do_reset();
    out_ready = 1'b1; start = 1'b1; start_pc = 10'd30;
    step(); start = 1'b0; #1;
    chk("fl_c1_addr", imem_addr, 30);
    step(); step(); #1;
    chk("fl_c3_valid", out_valid, 0);
    chk("fl_c3_req", flush_req, 0);
    chk("fl_c3_word", instr_q, mem[30]);
    flush_done = 1'b1;
    step(); flush_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      #1;
      chk("fl_req", flush_req, 1);
      chk("fl_stall_valid", out_valid, 0);
      chk("fl_stall_en", imem_en, 0);
    end
    flush_done = 1'b1;
    step(); flush_done = 1'b0; #1;
    chk("fl_ok_valid", out_valid, 1);
    chk("fl_ok_word", instr_q, mem[30]);
    chk("fl_ok_req", flush_req, 0);
    chk("fl_ok_addr", imem_addr, 31);
    step(); step(); #1;
    chk("fl2_word", instr_q, mem[31]);
    chk("fl2_valid", out_valid, 0);
    step(); #1;
    chk("fl2_req", flush_req, 1);

    // PC wrap
    do_reset();
    out_ready = 1'b1; start = 1'b1; start_pc = 10'h3FF;
    step(); start = 1'b0; #1;
    chk("wrap_addr0", imem_addr, 10'h3FF);
    step(); step(); #1;
    chk("wrap_word", instr_q, mem[10'h3FF]);
    chk("wrap_addr1", imem_addr, 0);

    // Randomized programs under varying backpressure
    for (int i = 0; i < 1024; i++) begin
      int r;
      r = $urandom_range(0, 39);
      mem[i] = mk(r == 0 ? 3 : r < 6 ? 1 : r < 11 ? 2 : r == 11 ? 4 : 0);
    end
    rand_run(100);
    rand_run(60);
    rand_run(25);
    rand_run(80);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch sequencer directly upstream of the pre-decode stage.
- Drives instruction-memory reads from a program counter and holds each fetched word in a one-entry output register.
- The held word feeds the pre-decode logic combinationally; the block uses the returned branch, end and flush flags to stall, hand off or terminate.
- Issues words to the decode/exec stage with a valid/ready handshake.

Parameters:
- INSTR_W, 64, instruction width in bits (equals `INSTR_WIDTH).
- ADDR_W, 10, instruction-memory address width; the PC wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse that starts or restarts execution.
- start_pc  in  ADDR_W  first fetch address, sampled on an accepted start.
- imem_en  out  1  instruction-memory read enable.
- imem_addr  out  ADDR_W  read address (current PC).
- imem_rdata  in  INSTR_W  read data, valid exactly one cycle after imem_en.
- instr_q  out  INSTR_W  held instruction; feeds pre-decode and downstream decode.
- pd_is_branch  in  1  pre-decode flag for instr_q.
- pd_is_end  in  1  pre-decode flag for instr_q.
- pd_need_flush  in  1  pre-decode flag for instr_q.
- out_valid  out  1  instr_q is offered downstream.
- out_ready  in  1  downstream accepts.
- br_resolve_valid  in  1  exec resolved the last branch (also used for sleep wake-up).
- br_taken  in  1  resolved branch was taken.
- br_target  in  ADDR_W  resolved branch target.
- flush_req  out  1  request to drain the readback buffer.
- flush_done  in  1  pulse: readback buffer drained.
- busy  out  1  state is not IDLE and not DONE.
- done  out  1  end instruction handed off; held until the next start or rst.

Behaviour:
- States: IDLE, FETCH, WAIT_BR, WAIT_FLUSH, DONE.
- Reset values: all state to IDLE; pc=0; inflight=0; instr_valid=0; flush_ok=0; instr_q=0.
- Reset outputs: imem_en=0, out_valid=0, flush_req=0, busy=0, done=0.
- rst mid-operation: a read in flight is discarded; imem_rdata in the cycle after rst is ignored.
- Accepted start (IDLE or DONE only):
  - pc<=start_pc; done<=0; state<=FETCH.
  - start in any other state is ignored.
- Fetch issue (combinational):
  - imem_en = (state==FETCH) && !inflight && (!instr_valid || hs_normal).
  - On issue: pc<=pc+1 (wraps) and inflight<=1.
- Capture: the cycle after issue, instr_q<=imem_rdata, instr_valid<=1, inflight<=0.
- Throughput: at most one instruction per 2 cycles. This is fixed; there is no speculative prefetch.
- Handshakes:
  - hs = out_valid && out_ready.
  - hs_normal = hs && !pd_is_branch && !pd_is_end.
- out_valid = instr_valid && (state==FETCH) && (!pd_need_flush || flush_ok).
- Flag precedence on instr_valid in FETCH, highest first:
  - need_flush (without flush_ok): out_valid=0, state<=WAIT_FLUSH.
  - end: on hs, state<=DONE, done<=1.
  - branch: on hs, state<=WAIT_BR.
- Normal hs: instr_valid<=0 unless a capture lands in the same cycle. A capture always wins, since at most one read is in flight.
- WAIT_FLUSH:
  - flush_req=1 continuously.
  - On flush_done: flush_ok<=1, state<=FETCH.
  - flush_ok clears on the next hs.
  - The word is then offered even if read_size still exceeds buffer space, so an oversized read can never deadlock.
- WAIT_BR:
  - No fetches.
  - On br_resolve_valid: pc<=(br_taken ? br_target : pc), state<=FETCH.
  - Sleep words are flagged as branches by pre-decode and take this same path; exec wakes fetch with br_resolve_valid, br_taken=0.
- br_resolve_valid outside WAIT_BR is ignored. flush_done outside WAIT_FLUSH is ignored.
- out_valid, once high, stays high with instr_q stable until hs. Downstream may hold out_ready low indefinitely.
- DONE: no fetches, out_valid=0, done=1.

Test Plan:
- Straight line: start_pc=5, three normal words, out_ready=1 → imem_addr 5,6,7 on cycles 1,3,5; hs on cycles 3,5,7; words delivered in order.
- Backpressure: out_ready=0 for 4 cycles on the first word → instr_q stable, no second imem_en, resume spacing 2 once ready.
- Taken branch at addr 3 → hs, no fetch of addr 4 → br_resolve_valid, br_taken=1, br_target=0x3F0 → next imem_addr=0x3F0. Not taken → next imem_addr=4.
- Flush: need_flush word → out_valid=0, flush_req=1 for 10 cycles → flush_done → out_valid next cycle with pd_need_flush still 1 → hs; the following need_flush word stalls again.
- End: all-zero word at addr 9 → hs → done=1, busy=0, no further imem_en; start with start_pc=0 → done=0, fetch addr 0.
- Wrap/reset: start_pc=0x3FF → fetches 0x3FF then 0x000. rst asserted the cycle after an issue → next cycle all outputs at reset values, stale imem_rdata not captured.
